conv2_window_gen: RTL and testbench
===================================

CONV2_WINDOW_GEN -- requirements
Module: conv2_window_gen

Interface
REQ-001 SHALL have parameter PIX_W, default 16, meaning signed two's-complement pixel width.
REQ-002 SHALL have parameter ROW_PIX, default 14, meaning pixels per pooled row and rows per frame.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  pooled row present on in_row.
REQ-006 SHALL have port in_ready  output  1  block accepts a row this cycle.
REQ-007 SHALL have port in_row  input  ROW_PIX*PIX_W  pooled row, pixel k at bits [k*PIX_W+PIX_W-1 : k*PIX_W].
REQ-008 SHALL have port win_valid  output  1  3x3 window present on win_data.
REQ-009 SHALL have port win_ready  input  1  downstream conv stage accepts window.
REQ-010 SHALL have port win_data  output  9*PIX_W  tap (r,c), r,c in 0..2 (r=0 top, c=0 left), at slot 3r+c.
REQ-011 SHALL have ports win_row, win_col  output  4 each  centre coordinate of current window, 0..ROW_PIX-1.
REQ-012 SHALL have port frame_done  output  1  single-cycle pulse after last window of a frame.

Function
REQ-013 Frame SHALL be ROW_PIX input rows; row transfer occurs on in_valid && in_ready.
REQ-014 Window (y,x) SHALL hold input pixel (y+r-1, x+c-1) at tap (r,c); out-of-range coordinates SHALL read 0.
REQ-015 Rows SHALL be stored in a 3-slot circular line buffer, slot = row index mod 3.
REQ-016 States SHALL be IDLE, FILL, EMIT; IDLE and FILL drive in_ready=1, EMIT drives in_ready=0.
REQ-017 IDLE -> FILL on acceptance of row 0; FILL -> EMIT on acceptance of row y+1 (y = next output row).
REQ-018 EMIT SHALL issue windows x=0..ROW_PIX-1 for row y; win_valid SHALL rise the cycle after the enabling row transfer.
REQ-019 win_data, win_row, win_col SHALL stay stable while win_valid && !win_ready; x advances only on handshake.
REQ-020 After the last window of row y<ROW_PIX-2: EMIT -> FILL next cycle.
REQ-021 After the last window of row ROW_PIX-2: remain EMIT for row ROW_PIX-1 with bottom taps 0, no input needed.
REQ-022 After the last window of row ROW_PIX-1: next cycle frame_done=1, state IDLE, in_ready=1.
REQ-023 in_valid while in_ready=0 SHALL be ignored; in_row is not captured.
REQ-024 Throughput: one window per cycle when win_ready held high; no bubble between windows of a row.

Reset
REQ-025 During rst: in_ready=0, win_valid=0, win_data=0, win_row=0, win_col=0, frame_done=0, state IDLE.
REQ-026 First cycle after rst deasserts SHALL show in_ready=1.
REQ-027 rst mid-frame SHALL discard buffered rows and window position; next accepted row is row 0.

Configuration
REQ-028 With CONV2_RELU_EN defined, pixels with sign bit set SHALL be stored as 0 (ReLU at capture).
REQ-029 Without CONV2_RELU_EN, pixels SHALL be stored unmodified.

Verification
REQ-030 Frame with pixel(y,x)=16*y+x, win_ready=1 -> 196 windows; window (0,0) taps = {0,0,0,0,0x0000,0x0001,0,0x0010,0x0011}; frame_done once.
REQ-031 Window (13,13) of same frame -> taps = {0x00CC,0x00CD,0,0x00DC,0x00DD,0,0,0,0}, win_row=13, win_col=13.
REQ-032 win_ready low for 5 cycles at window (4,7) -> win_data, win_col=7 unchanged throughout; next handshake gives win_col=8.
REQ-033 in_valid held high continuously -> in_ready=0 throughout each EMIT; exactly 14 rows captured per frame.
REQ-034 rst pulsed after 6 rows accepted -> outputs 0; new full frame output matches REQ-030 exactly.
REQ-035 Pixel 0xFF80 at (2,3): CONV2_RELU_EN defined -> tap reads 0x0000; undefined -> 0xFF80.

Source files
------------

// File: rtl/conv2_window_gen.sv
// conv2_window_gen
//
// Turns a stream of pooled image rows into a raster-ordered stream of 3x3
// windows for the following convolution stage. One window is produced per
// output pixel, and each window is centred on that pixel. Taps that fall
// outside the frame read as zero. A frame is ROW_PIX rows of ROW_PIX pixels.
// Input rows go into a three-slot circular line buffer, using slot = row mod 3.
// The row above, the current row and the row below are read from that buffer.
//
// Build option:
//   CONV2_RELU_EN  when defined, a negative pixel is stored as zero at capture
//                  (a ReLU on the incoming data). When undefined, pixels are
//                  stored unmodified.
//
// Parameters:
//   PIX_W      signed two's-complement pixel width
//   ROW_PIX    pixels per pooled row, and also rows per frame (max 16)
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    a pooled row is present on in_row
//   in_ready    the block accepts a row this cycle
//   in_row      pooled row; pixel k sits at bits [k*PIX_W +: PIX_W]
//   win_valid   a 3x3 window is present on win_data
//   win_ready   the downstream stage accepts the window
//   win_data    tap (r,c) at slot 3r+c; r=0 is the top row, c=0 is the left column
//   win_row     centre row of the current window
//   win_col     centre column of the current window
//   frame_done  single-cycle pulse after the last window of a frame
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | between frames, waiting for row 0
// FILL  | waiting for the row below the next output row
// EMIT  | issuing windows x = 0..ROW_PIX-1 for output row win_row

module conv2_window_gen #(
    parameter int PIX_W   = 16,
    parameter int ROW_PIX = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROW_PIX*PIX_W-1:0] in_row,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [9*PIX_W-1:0]       win_data,
    output logic [3:0]               win_row,
    output logic [3:0]               win_col,
    output logic                     frame_done
);

    localparam logic [3:0] LAST_IDX   = 4'(ROW_PIX - 1);
    localparam logic [3:0] PENULT_IDX = 4'(ROW_PIX - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t state;

    logic [ROW_PIX*PIX_W-1:0] line_buf [3];
    logic [ROW_PIX*PIX_W-1:0] cap_row;

    logic [1:0] wr_slot;
    logic [1:0] mid_slot;
    logic [1:0] top_slot;
    logic [1:0] bot_slot;

    logic row_acc;
    logic win_acc;

    function automatic logic [PIX_W-1:0] capture_pix(input logic [PIX_W-1:0] pix);
`ifdef CONV2_RELU_EN
        return pix[PIX_W-1] ? '0 : pix;
`else
        return pix;
`endif
    endfunction

    // in_ready is decoded from the state so that the first cycle after reset
    // already accepts a row. It is held low while reset is asserted.
    assign in_ready = !rst && (state != S_EMIT);
    assign row_acc  = in_valid && in_ready;
    assign win_acc  = win_valid && win_ready;

    for (genvar k = 0; k < ROW_PIX; k++) begin : g_cap
        assign cap_row[k*PIX_W +: PIX_W] = capture_pix(in_row[k*PIX_W +: PIX_W]);
    end

    // The line buffer needs no reset. Every tap that is read in a new frame
    // is written in that frame before its first window is issued.
    always_ff @(posedge clk) begin
        if (row_acc) begin
            line_buf[wr_slot] <= cap_row;
        end
    end

    // Slots of the rows above and below the centre row, taken mod 3.
    assign top_slot = (mid_slot == 2'd0) ? 2'd2 : mid_slot - 2'd1;
    assign bot_slot = (mid_slot == 2'd2) ? 2'd0 : mid_slot + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            win_valid  <= 1'b0;
            win_row    <= 4'd0;
            win_col    <= 4'd0;
            frame_done <= 1'b0;
            wr_slot    <= 2'd0;
            mid_slot   <= 2'd0;
        end else begin
            frame_done <= 1'b0;

            if (row_acc) begin
                wr_slot <= (wr_slot == 2'd2) ? 2'd0 : wr_slot + 2'd1;
            end

            unique case (state)
                S_IDLE: begin
                    if (row_acc) begin
                        state <= S_FILL;
                    end
                end

                // Each row accepted here is the row below the next output
                // row, so it always completes that row's neighbourhood.
                S_FILL: begin
                    if (row_acc) begin
                        state     <= S_EMIT;
                        win_valid <= 1'b1;
                    end
                end

                S_EMIT: begin
                    if (win_acc) begin
                        if (win_col != LAST_IDX) begin
                            win_col <= win_col + 4'd1;
                        end else begin
                            win_col <= 4'd0;
                            if (win_row == LAST_IDX) begin
                                state      <= S_IDLE;
                                win_valid  <= 1'b0;
                                frame_done <= 1'b1;
                                win_row    <= 4'd0;
                                mid_slot   <= 2'd0;
                                wr_slot    <= 2'd0;
                            end else begin
                                win_row  <= win_row + 4'd1;
                                mid_slot <= bot_slot;
                                // The last row has no row below it, so it
                                // follows straight on without fetching input.
                                if (win_row != PENULT_IDX) begin
                                    state     <= S_FILL;
                                    win_valid <= 1'b0;
                                end
                            end
                        end
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    win_valid <= 1'b0;
                end
            endcase
        end
    end

    // Window taps are decoded directly from the buffer and the registered
    // position. The buffer is not written during EMIT, so win_data stays
    // stable while the window waits for win_ready.
    for (genvar r = 0; r < 3; r++) begin : g_r
        for (genvar c = 0; c < 3; c++) begin : g_c
            logic       row_ok;
            logic       col_ok;
            logic [1:0] slot;
            logic [3:0] col;

            if (r == 0) begin : g_top
                assign slot   = top_slot;
                assign row_ok = (win_row != 4'd0);
            end else if (r == 1) begin : g_mid
                assign slot   = mid_slot;
                assign row_ok = 1'b1;
            end else begin : g_bot
                assign slot   = bot_slot;
                assign row_ok = (win_row != LAST_IDX);
            end

            // The column index stays in range even when the tap is masked.
            if (c == 0) begin : g_left
                assign col_ok = (win_col != 4'd0);
                assign col    = col_ok ? win_col - 4'd1 : win_col;
            end else if (c == 1) begin : g_ctr
                assign col_ok = 1'b1;
                assign col    = win_col;
            end else begin : g_right
                assign col_ok = (win_col != LAST_IDX);
                assign col    = col_ok ? win_col + 4'd1 : win_col;
            end

            assign win_data[(3*r+c)*PIX_W +: PIX_W] =
                (win_valid && row_ok && col_ok) ? line_buf[slot][col*PIX_W +: PIX_W] : '0;
        end
    end

endmodule

// File: tb/tb_conv2_window_gen.sv
// tb_conv2_window_gen
//
// Directed bench for conv2_window_gen. It covers:
//   - the reset state
//   - a full raster frame
//   - a downstream stall
//   - in_valid held high continuously
//   - a reset in the middle of a frame
//   - the capture path for a negative pixel
//
// Expected windows come from a small reference model of the 3x3 neighbourhood
// with zero padding.

module tb_conv2_window_gen;

    localparam int PIX_W   = 16;
    localparam int ROW_PIX = 14;
    localparam int WIN_W   = 9 * PIX_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [ROW_PIX*PIX_W-1:0] in_row;
    logic                     win_valid;
    logic                     win_ready;
    logic [WIN_W-1:0]         win_data;
    logic [3:0]               win_row;
    logic [3:0]               win_col;
    logic                     frame_done;

    int tests_run    = 0;
    int tests_failed = 0;

    // Observations recorded by run_frame.
    logic [WIN_W-1:0] got_data [ROW_PIX][ROW_PIX];
    bit               got_seen [ROW_PIX][ROW_PIX];
    int               win_count;
    int               done_count;
    int               rows_taken;
    int               bad_ready;
    int               order_bad;
    int               first_valid_cyc;
    int               row1_cyc;
    int               stall_seen;
    int               stall_bad;
    int               next_col;
    bit               timed_out;
    bit               neg_pix = 1'b0;

    conv2_window_gen #(.PIX_W(PIX_W), .ROW_PIX(ROW_PIX)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [PIX_W-1:0] pix(input int y, input int x);
        if (neg_pix && y == 2 && x == 3) return 16'hFF80;
        return 16'(16 * y + x);
    endfunction

    function automatic logic [PIX_W-1:0] stored_pix(input int y, input int x);
        logic [PIX_W-1:0] p;
        p = pix(y, x);
`ifdef CONV2_RELU_EN
        if (p[PIX_W-1]) p = '0;
`endif
        return p;
    endfunction

    function automatic logic [ROW_PIX*PIX_W-1:0] row_vec(input int y);
        logic [ROW_PIX*PIX_W-1:0] v;
        v = '0;
        for (int x = 0; x < ROW_PIX; x++) v[x*PIX_W +: PIX_W] = pix(y, x);
        return v;
    endfunction

    function automatic logic [WIN_W-1:0] exp_win(input int y, input int x);
        logic [WIN_W-1:0] w;
        int yy, xx;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                yy = y + r - 1;
                xx = x + c - 1;
                if (yy >= 0 && yy < ROW_PIX && xx >= 0 && xx < ROW_PIX)
                    w[(3*r+c)*PIX_W +: PIX_W] = stored_pix(yy, xx);
            end
        end
        return w;
    endfunction

    task automatic count_win_errors(output int errs, output int ey, output int ex);
        errs = 0;
        ey = -1;
        ex = -1;
        for (int y = 0; y < ROW_PIX; y++) begin
            for (int x = 0; x < ROW_PIX; x++) begin
                if (!got_seen[y][x] || got_data[y][x] !== exp_win(y, x)) begin
                    if (errs == 0) begin
                        ey = y;
                        ex = x;
                    end
                    errs++;
                end
            end
        end
    endtask

    // Drives one frame and records every window handshake.
    //   hold_mode   keeps in_valid high throughout, with junk on in_row
    //               whenever the row would not be accepted
    //   stall_mode  holds win_ready low for 5 cycles while window (4,7) is shown
    //   stop_rows   when non-zero, returns as soon as that many rows are accepted
    task automatic run_frame(input bit hold_mode, input bit stall_mode, input int stop_rows);
        int row_idx = 0;
        int cyc = 0;
        int seq = 0;
        int done_cyc = -1;
        int stall_left;
        bit look_next = 1'b0;
        bit fin = 1'b0;
        logic [WIN_W-1:0] snap = '0;
        logic [ROW_PIX*PIX_W-1:0] junk;
        junk = {ROW_PIX{16'hA5A5}};
        for (int y = 0; y < ROW_PIX; y++)
            for (int x = 0; x < ROW_PIX; x++) begin
                got_seen[y][x] = 1'b0;
                got_data[y][x] = '0;
            end
        win_count = 0;
        done_count = 0;
        rows_taken = 0;
        bad_ready = 0;
        order_bad = 0;
        first_valid_cyc = -1;
        row1_cyc = -1;
        stall_seen = 0;
        stall_bad = 0;
        next_col = -1;
        timed_out = 1'b0;
        stall_left = stall_mode ? 5 : 0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin
                timed_out = 1'b1;
                fin = 1'b1;
            end else if (stop_rows > 0 && rows_taken >= stop_rows) begin
                fin = 1'b1;
            end else begin
                if (frame_done === 1'b1) begin
                    done_count++;
                    if (done_cyc < 0) done_cyc = cyc;
                end
                if (done_cyc >= 0 && cyc >= done_cyc + 3) begin
                    fin = 1'b1;
                end else begin
                    if (done_cyc >= 0) begin
                        in_valid = 1'b0;
                        in_row = '0;
                    end else if (hold_mode) begin
                        in_valid = 1'b1;
                        in_row = (in_ready && row_idx < ROW_PIX) ? row_vec(row_idx) : junk;
                    end else begin
                        in_valid = (row_idx < ROW_PIX);
                        in_row = (row_idx < ROW_PIX) ? row_vec(row_idx) : '0;
                    end
                    win_ready = 1'b1;
                    if (win_valid && win_row == 4'd4 && win_col == 4'd7 && stall_left > 0) begin
                        win_ready = 1'b0;
                        stall_left--;
                        if (stall_seen == 0) snap = win_data;
                        else if (win_data !== snap || win_col !== 4'd7) stall_bad++;
                        stall_seen++;
                    end
                    if (in_valid && in_ready) begin
                        if (row_idx == 1) row1_cyc = cyc;
                        row_idx++;
                        rows_taken++;
                    end
                    if (win_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                    if (win_valid && in_ready) bad_ready++;
                    if (win_valid && win_ready) begin
                        if (look_next) begin
                            next_col = int'(win_col);
                            look_next = 1'b0;
                        end
                        if (stall_mode && win_row == 4'd4 && win_col == 4'd7 && stall_seen == 5)
                            look_next = 1'b1;
                        if (int'(win_row) != seq / ROW_PIX || int'(win_col) != seq % ROW_PIX)
                            order_bad++;
                        seq++;
                        if (int'(win_row) < ROW_PIX && int'(win_col) < ROW_PIX) begin
                            got_data[win_row][win_col] = win_data;
                            got_seen[win_row][win_col] = 1'b1;
                        end
                        win_count++;
                    end
                end
            end
        end
        in_valid = 1'b0;
        in_row = '0;
        win_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: in_ready=%b win_valid=%b frame_done=%b, required 0 0 0",
                     in_ready, win_valid, frame_done);
        end
        tests_run++;
        if (win_data !== '0 || win_row !== 4'd0 || win_col !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_data: win_data=%h row=%0d col=%0d, required all zero",
                     win_data, win_row, win_col);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_frame();
        int errs, ey, ex;
        logic [WIN_W-1:0] w00, w1313;
        w00   = {16'h0011, 16'h0010, 16'h0000, 16'h0001, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        w1313 = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h00DD,
                 16'h00DC, 16'h0000, 16'h00CD, 16'h00CC};
        run_frame(1'b0, 1'b0, 0);
        tests_run++;
        if (timed_out) begin
            tests_failed++;
            $display("FAIL frame_timeout: frame did not finish within the cycle budget");
        end
        tests_run++;
        if (win_count != 196) begin
            tests_failed++;
            $display("FAIL frame_win_count: got %0d, required 196", win_count);
        end
        tests_run++;
        if (done_count != 1) begin
            tests_failed++;
            $display("FAIL frame_done_count: got %0d, required 1", done_count);
        end
        tests_run++;
        if (rows_taken != 14) begin
            tests_failed++;
            $display("FAIL frame_rows: got %0d, required 14", rows_taken);
        end
        count_win_errors(errs, ey, ex);
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL frame_windows: %0d bad windows, first at (%0d,%0d), required 0", errs, ey, ex);
        end
        tests_run++;
        if (order_bad != 0) begin
            tests_failed++;
            $display("FAIL frame_order: %0d out-of-order windows, required 0", order_bad);
        end
        tests_run++;
        if (got_data[0][0] !== w00) begin
            tests_failed++;
            $display("FAIL win_0_0: got %h, required %h", got_data[0][0], w00);
        end
        tests_run++;
        if (!got_seen[13][13] || got_data[13][13] !== w1313) begin
            tests_failed++;
            $display("FAIL win_13_13: got %h, required %h", got_data[13][13], w1313);
        end
        tests_run++;
        if (row1_cyc < 0 || first_valid_cyc != row1_cyc + 1) begin
            tests_failed++;
            $display("FAIL first_valid_latency: win_valid cycle %0d, required %0d",
                     first_valid_cyc, row1_cyc + 1);
        end
        tests_run++;
        if (in_ready !== 1'b1 || win_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_end_state: in_ready=%b win_valid=%b, required 1 0", in_ready, win_valid);
        end
    endtask

    task automatic test_stall();
        int errs, ey, ex;
        run_frame(1'b0, 1'b1, 0);
        tests_run++;
        if (timed_out || win_count != 196) begin
            tests_failed++;
            $display("FAIL stall_count: windows %0d timeout %b, required 196 0", win_count, timed_out);
        end
        tests_run++;
        if (stall_seen != 5) begin
            tests_failed++;
            $display("FAIL stall_cycles: got %0d, required 5", stall_seen);
        end
        tests_run++;
        if (stall_bad != 0) begin
            tests_failed++;
            $display("FAIL stall_stable: %0d cycles changed, required 0", stall_bad);
        end
        tests_run++;
        if (next_col != 8) begin
            tests_failed++;
            $display("FAIL stall_next_col: got %0d, required 8", next_col);
        end
        count_win_errors(errs, ey, ex);
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL stall_windows: %0d bad windows, first at (%0d,%0d), required 0", errs, ey, ex);
        end
    endtask

    task automatic test_in_valid_held();
        int errs, ey, ex;
        run_frame(1'b1, 1'b0, 0);
        tests_run++;
        if (timed_out || bad_ready != 0) begin
            tests_failed++;
            $display("FAIL held_ready_in_emit: %0d cycles with in_ready=1 in EMIT, timeout %b, required 0 0",
                     bad_ready, timed_out);
        end
        tests_run++;
        if (rows_taken != 14) begin
            tests_failed++;
            $display("FAIL held_rows: got %0d, required 14", rows_taken);
        end
        count_win_errors(errs, ey, ex);
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL held_windows: %0d bad windows, first at (%0d,%0d), required 0", errs, ey, ex);
        end
        tests_run++;
        if (done_count != 1) begin
            tests_failed++;
            $display("FAIL held_done_count: got %0d, required 1", done_count);
        end
    endtask

    task automatic test_mid_reset();
        int errs, ey, ex;
        logic [WIN_W-1:0] w00;
        w00 = {16'h0011, 16'h0010, 16'h0000, 16'h0001, 16'h0000,
               16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_frame(1'b0, 1'b0, 6);
        tests_run++;
        if (rows_taken != 6) begin
            tests_failed++;
            $display("FAIL midrst_rows: got %0d, required 6", rows_taken);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (win_valid !== 1'b0 || win_data !== '0 || win_row !== 4'd0 || win_col !== 4'd0 ||
            in_ready !== 1'b0 || frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: valid=%b data=%h row=%0d col=%0d ready=%b done=%b, required all zero",
                     win_valid, win_data, win_row, win_col, in_ready, frame_done);
        end
        rst = 1'b0;
        run_frame(1'b0, 1'b0, 0);
        count_win_errors(errs, ey, ex);
        tests_run++;
        if (timed_out || win_count != 196 || done_count != 1) begin
            tests_failed++;
            $display("FAIL midrst_frame: windows %0d done %0d timeout %b, required 196 1 0",
                     win_count, done_count, timed_out);
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL midrst_windows: %0d bad windows, first at (%0d,%0d), required 0", errs, ey, ex);
        end
        tests_run++;
        if (got_data[0][0] !== w00) begin
            tests_failed++;
            $display("FAIL midrst_win_0_0: got %h, required %h", got_data[0][0], w00);
        end
    endtask

    task automatic test_relu();
        int errs, ey, ex;
        logic [PIX_W-1:0] exp_tap;
`ifdef CONV2_RELU_EN
        exp_tap = 16'h0000;
`else
        exp_tap = 16'hFF80;
`endif
        neg_pix = 1'b1;
        run_frame(1'b0, 1'b0, 0);
        tests_run++;
        if (got_data[2][3][4*PIX_W +: PIX_W] !== exp_tap) begin
            tests_failed++;
            $display("FAIL relu_centre_tap: got %h, required %h", got_data[2][3][4*PIX_W +: PIX_W], exp_tap);
        end
        tests_run++;
        if (got_data[1][2][8*PIX_W +: PIX_W] !== exp_tap) begin
            tests_failed++;
            $display("FAIL relu_corner_tap: got %h, required %h", got_data[1][2][8*PIX_W +: PIX_W], exp_tap);
        end
        count_win_errors(errs, ey, ex);
        tests_run++;
        if (timed_out || errs != 0) begin
            tests_failed++;
            $display("FAIL relu_windows: %0d bad windows, first at (%0d,%0d), timeout %b, required 0 0",
                     errs, ey, ex, timed_out);
        end
        neg_pix = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_row    = '0;
        win_ready = 1'b0;
        test_reset();
        test_frame();
        test_stall();
        test_in_valid_held();
        test_mid_reset();
        test_relu();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
